// File: rtl/mss_clk_rst_core.sv
// Clock/reset front end: SYSCLK divider, reset synchroniser, lock delay and fabric reset release.
// Define MSS_WATCHDOG_EN to build the watchdog that can re-sequence the fabric reset.
module mss_clk_rst_core #(
  parameter int unsigned FAB_DIV         = 2,
  parameter int unsigned RST_SYNC_STAGES = 2,
  parameter int unsigned LOCK_CYCLES     = 16,
  parameter int unsigned WDOG_CYCLES     = 1024
) (
  input  logic SYSCLK,
  input  logic MSS_RESET_N,
  output logic FAB_CLK,
  output logic M2F_RESET_N,
  output logic MSS_LOCK,
  input  logic WDOG_KICK,
  output logic WDOG_TIMEOUT
);

  localparam int unsigned HALF   = FAB_DIV / 2;
  localparam int unsigned DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [RST_SYNC_STAGES-1:0] sync_q;
  logic                       rst_s_n;
  logic [DIV_W-1:0]           div_cnt;
  logic                       div_wrap;
  logic                       fab_fall;
  logic [LOCK_W-1:0]          lock_cnt;
  logic                       wd_expire;

  // Asynchronous assert, synchronous deassert through RST_SYNC_STAGES flops.
  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) sync_q <= '0;
    else              sync_q <= {sync_q[RST_SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_s_n  = sync_q[RST_SYNC_STAGES-1];
  assign div_wrap = rst_s_n && (div_cnt == DIV_W'(HALF - 1));
  assign fab_fall = div_wrap && FAB_CLK;

  // FAB_CLK is a flop output; it toggles only when the half-period counter wraps.
  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      div_cnt <= '0;
      FAB_CLK <= 1'b0;
    end else if (!rst_s_n) begin
      div_cnt <= '0;
      FAB_CLK <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      FAB_CLK <= ~FAB_CLK;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Lock delay; MSS_LOCK holds until reset or watchdog expiry restarts the count.
  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      lock_cnt <= '0;
      MSS_LOCK <= 1'b0;
    end else if (!rst_s_n || wd_expire) begin
      lock_cnt <= '0;
      MSS_LOCK <= 1'b0;
    end else if (!MSS_LOCK) begin
      if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) MSS_LOCK <= 1'b1;
      else                                      lock_cnt <= lock_cnt + LOCK_W'(1);
    end
  end

  // Fabric reset releases only on a FAB_CLK falling toggle, never on a rising one.
  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N)                 M2F_RESET_N <= 1'b0;
    else if (!rst_s_n || wd_expire)   M2F_RESET_N <= 1'b0;
    else if (MSS_LOCK && fab_fall)    M2F_RESET_N <= 1'b1;
  end

`ifdef MSS_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES);

  logic [WD_W-1:0] wd_cnt;

  // A kick on the expiry cycle takes priority and suppresses the timeout.
  assign wd_expire = M2F_RESET_N && !WDOG_KICK && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      wd_cnt       <= '0;
      WDOG_TIMEOUT <= 1'b0;
    end else begin
      WDOG_TIMEOUT <= wd_expire;
      if (WDOG_KICK || wd_expire) wd_cnt <= '0;
      else if (M2F_RESET_N)       wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  logic unused_wdog;

  assign wd_expire    = 1'b0;
  assign WDOG_TIMEOUT = 1'b0;
  assign unused_wdog  = WDOG_KICK ^ (WDOG_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mss_clk_rst_core.sv
// Bench for mss_clk_rst_core: default instance plus FAB_DIV=6/LOCK_CYCLES=5 instance, checked against an edge-count model.
module tb_mss_clk_rst_core;

  localparam int STAGES = 2;
  localparam int WC     = 1024;
  localparam int HALF_P [2] = '{1, 3};
  localparam int LOCK_P [2] = '{16, 5};
`ifdef MSS_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic kick0 = 1'b0;
  logic kick1 = 1'b1;
  logic fab0, m2f0, lock0, to0;
  logic fab1, m2f1, lock1, to1;
  logic [3:0] obs [2];

  int total = 0;
  int bad   = 0;

  always #50 clk = ~clk;

  mss_clk_rst_core dut (
    .SYSCLK(clk), .MSS_RESET_N(rst_n), .FAB_CLK(fab0), .M2F_RESET_N(m2f0),
    .MSS_LOCK(lock0), .WDOG_KICK(kick0), .WDOG_TIMEOUT(to0));

  mss_clk_rst_core #(.FAB_DIV(6), .LOCK_CYCLES(5)) dut6 (
    .SYSCLK(clk), .MSS_RESET_N(rst_n), .FAB_CLK(fab1), .M2F_RESET_N(m2f1),
    .MSS_LOCK(lock1), .WDOG_KICK(kick1), .WDOG_TIMEOUT(to1));

  assign obs[0] = {fab0, lock0, m2f0, to0};
  assign obs[1] = {fab1, lock1, m2f1, to1};

  // Reference model: everything derived from the number of SYSCLK edges since release.
  int since;
  int base   [2];
  int wd_ref [2];
  bit m_fab [2], m_lock [2], m_m2f [2], m_to [2];

  function automatic bit fab_at(int k, int h);
    if (k < STAGES) return 1'b0;
    return ((k - STAGES) / h) % 2 == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since = 0;
      for (int i = 0; i < 2; i++) begin
        base[i] = STAGES; wd_ref[i] = 0;
        m_fab[i] = 1'b0; m_lock[i] = 1'b0; m_m2f[i] = 1'b0; m_to[i] = 1'b0;
      end
    end else begin
      since++;
      for (int i = 0; i < 2; i++) begin
        bit pf, pl, pm, kk;
        pf = m_fab[i]; pl = m_lock[i]; pm = m_m2f[i];
        kk = (i == 0) ? kick0 : kick1;
        m_to[i] = 1'b0;
        if (kk) wd_ref[i] = since;
        else if (WD_ON && i == 0 && pm && (since - wd_ref[i] == WC)) begin
          m_to[i] = 1'b1;
          base[i] = since;
        end
        m_fab[i]  = fab_at(since, HALF_P[i]);
        m_lock[i] = since >= base[i] + LOCK_P[i];
        if (m_to[i]) m_m2f[i] = 1'b0;
        else if (!pm && pl && pf && !m_fab[i]) begin
          m_m2f[i]  = 1'b1;
          wd_ref[i] = since;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== 4'b0000) begin
          bad++;
          $display("FAIL reset_hold dut%0d got fab/lock/m2f/to=%b want 0000", i, obs[i]);
        end
      end
    end
  endtask

  // Release reset and check lock latency (sync stages + lock cycles) plus per-cycle outputs.
  task automatic release_and_check(input string tag, input int cycles);
    int lat [2];
    lat[0] = -1; lat[1] = -1;
    @(negedge clk);
    #10 rst_n = 1'b1;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== {m_fab[i], m_lock[i], m_m2f[i], m_to[i]}) begin
          bad++;
          $display("FAIL %s dut%0d cyc=%0d got fab/lock/m2f/to=%b want %b", tag, i, c, obs[i],
                   {m_fab[i], m_lock[i], m_m2f[i], m_to[i]});
        end
        if (lat[i] < 0 && obs[i][2]) lat[i] = c;
      end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (lat[i] != STAGES + LOCK_P[i]) begin
        bad++;
        $display("FAIL %s_lock_latency dut%0d got %0d edges want %0d", tag, i, lat[i], STAGES + LOCK_P[i]);
      end
    end
  endtask

  task automatic test_release();
    release_and_check("release", 60);
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      #($urandom_range(1, 40)) rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== 4'b0000) begin
          bad++;
          $display("FAIL mid_reset_async dut%0d got %b want 0000", i, obs[i]);
        end
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      // Partial sequence: abort after 8 lock cycles (edge 10) on the next pass.
      @(negedge clk);
      #10 rst_n = 1'b1;
      repeat (STAGES + 8) @(negedge clk);
      #($urandom_range(1, 40)) rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== 4'b0000) begin
          bad++;
          $display("FAIL mid_lock_abort dut%0d got %b want 0000", i, obs[i]);
        end
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      release_and_check("relock", 40);
    end
  endtask

  task automatic test_div_duty();
    int last_rise [2];
    bit prev [2];
    int want_hi;
    last_rise[0] = -1; last_rise[1] = -1;
    prev[0] = fab0; prev[1] = fab1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit f;
        f = obs[i][3];
        want_hi = HALF_P[i];
        if (f && !prev[i]) begin
          if (last_rise[i] >= 0) begin
            total++;
            if (c - last_rise[i] != 2 * want_hi) begin
              bad++;
              $display("FAIL fab_period dut%0d got %0d cycles want %0d", i, c - last_rise[i], 2 * want_hi);
            end
          end
          last_rise[i] = c;
        end else if (!f && prev[i] && last_rise[i] >= 0) begin
          total++;
          if (c - last_rise[i] != want_hi) begin
            bad++;
            $display("FAIL fab_high dut%0d got %0d cycles want %0d", i, c - last_rise[i], want_hi);
          end
        end
        prev[i] = f;
      end
    end
  endtask

  // Run with a kick policy: 0 none, 1 every 500 cycles, 2 exactly on expiry, 3 random.
  task automatic run_kicks(input string tag, input int mode, input int cycles, output int pulses);
    pulses = 0;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== {m_fab[i], m_lock[i], m_m2f[i], m_to[i]}) begin
          bad++;
          $display("FAIL %s dut%0d cyc=%0d got fab/lock/m2f/to=%b want %b", tag, i, c, obs[i],
                   {m_fab[i], m_lock[i], m_m2f[i], m_to[i]});
        end
      end
      if (to0) pulses++;
      case (mode)
        1:       kick0 = (c % 500 == 0);
        2:       kick0 = m_m2f[0] && (since + 1 - wd_ref[0] == WC);
        3:       kick0 = ($urandom_range(0, 799) == 0);
        default: kick0 = 1'b0;
      endcase
    end
    kick0 = 1'b0;
  endtask

`ifdef MSS_WATCHDOG_EN
  task automatic test_watchdog();
    int rise_c, to_c, relock_c, pulses;
    bit pm, pl;
    rise_c = -1; to_c = -1; relock_c = -1;
    rst_n = 1'b0;
    kick0 = 1'b0;
    repeat (3) @(negedge clk);
    #10 rst_n = 1'b1;
    pm = 1'b0; pl = 1'b0;
    for (int c = 1; c <= 1300; c++) begin
      @(negedge clk);
      total++;
      if (obs[0] !== {m_fab[0], m_lock[0], m_m2f[0], m_to[0]}) begin
        bad++;
        $display("FAIL wdog_expire cyc=%0d got %b want %b", c, obs[0], {m_fab[0], m_lock[0], m_m2f[0], m_to[0]});
      end
      if (rise_c < 0 && m2f0 && !pm) rise_c = c;
      if (to_c < 0 && to0) to_c = c;
      if (to_c >= 0 && relock_c < 0 && c > to_c && lock0 && !pl) relock_c = c;
      pm = m2f0; pl = lock0;
    end
    total++;
    if (rise_c < 0 || to_c - rise_c != WC) begin
      bad++;
      $display("FAIL wdog_timeout_delay got %0d want %0d (rise=%0d)", to_c - rise_c, WC, rise_c);
    end
    total++;
    if (to_c < 0 || relock_c - to_c != LOCK_P[0]) begin
      bad++;
      $display("FAIL wdog_relock_delay got %0d want %0d", relock_c - to_c, LOCK_P[0]);
    end
    run_kicks("wdog_kick500", 1, 5000, pulses);
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL wdog_kick500_pulses got %0d want 0", pulses);
    end
    run_kicks("wdog_kick_on_expiry", 2, 1700, pulses);
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL wdog_expiry_kick_pulses got %0d want 0", pulses);
    end
    run_kicks("wdog_random", 3, 4000, pulses);
  endtask
`else
  task automatic test_kick_ignored();
    int pulses;
    run_kicks("kick_ignored", 3, 1500, pulses);
    total++;
    if (pulses != 0 || m2f0 !== 1'b1) begin
      bad++;
      $display("FAIL kick_ignored got pulses=%0d m2f=%b want 0 and 1", pulses, m2f0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_div_duty();
    test_mid_reset();
`ifdef MSS_WATCHDOG_EN
    test_watchdog();
`else
    test_kick_ignored();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
